// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//
// Main control FSM for the multi-cycle MIPS core. Each instruction is walked
// through fetch / decode / execute / memory / write-back states, and the
// datapath enables and selects are driven for the current state. Memory
// accesses use a ready handshake guarded by a watchdog; undecodable opcodes
// and memory timeouts park the FSM in TRAP until reset.
//
// Ports
//   clk_i, rst_i       clock; synchronous active-low reset
//   start_i            leave IDLE and begin fetching
//   opcode_i           IR[31:26], stable after fetch
//   zero_i             ALU zero flag (branch decision)
//   mem_ready_i        memory completes the current access this cycle
//   pc_write_o         PC load enable
//   ir_write_o         IR load enable
//   iord_o             memory address select (0=PC, 1=ALUOut)
//   mem_read_o         memory read request
//   mem_write_o        memory write request
//   reg_write_o        register file write enable
//   reg_dst_o          destination register (1=rd, 0=rt)
//   mem_to_reg_o       write-back source (1=MDR, 0=ALUOut)
//   alu_src_a_o        ALU A (0=PC, 1=rs)
//   alu_src_b_o        ALU B (00=rt, 01=4, 10=ext imm, 11=sext imm<<2)
//   ext_zero_o         immediate extension (1=zero, 0=sign)
//   alu_op_o           ALU op (00=add, 01=sub, 10=funct, 11=or)
//   pc_src_o           PC source (00=ALU, 01=ALUOut, 10=jump target)
//   state_o            current state encoding
//   err_o              FSM is trapped
//   err_code_o         trap cause (01=illegal opcode, 10=memory timeout)
//   retire_cnt_o       retired instruction count (wraps)
// ---------------------------------------------------------------------------
module multicycle_control #(
  parameter int OP_W        = 6,
  parameter int TMO_W       = 8,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [OP_W-1:0]  opcode_i,
  input  logic             zero_i,
  input  logic             mem_ready_i,
  output logic             pc_write_o,
  output logic             ir_write_o,
  output logic             iord_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic             reg_write_o,
  output logic             reg_dst_o,
  output logic             mem_to_reg_o,
  output logic             alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic             ext_zero_o,
  output logic [1:0]       alu_op_o,
  output logic [1:0]       pc_src_o,
  output logic [3:0]       state_o,
  output logic             err_o,
  output logic [1:0]       err_code_o,
  output logic [CNT_W-1:0] retire_cnt_o
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_ORI = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_WB_R     = 4'd8,
    S_WB_MEM   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_TRAP     = 4'd12
  } state_e;

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_ORI   = OP_W'(6'b001101);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);

  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  logic [TMO_W-1:0] wd_q, wd_d, wd_inc;
  logic [1:0]       err_code_q, err_code_d;
  logic [CNT_W-1:0] retire_q, retire_d;
  logic             retire_en;
  logic             wait_st;
  logic             wd_expired;

  // -------------------------------------------------------------------------
  // Memory-wait watchdog. The counter only advances while a wait state is
  // stalled; any other cycle (including the ready cycle that leaves a wait
  // state) returns it to zero, so every wait state is entered with a clean
  // count. Expiry is judged on the incremented value so that the Nth stalled
  // cycle is the last one; a ready in that same cycle takes priority.
  // -------------------------------------------------------------------------
  always_comb begin
    wait_st    = (state_q == S_FETCH) || (state_q == S_MEM_RD) ||
                 (state_q == S_MEM_WR);
    wd_inc     = wd_q + TMO_W'(1);
    wd_expired = wait_st && !mem_ready_i && (wd_inc == TMO_LIMIT);
    wd_d       = (wait_st && !mem_ready_i) ? wd_inc : '0;
  end

  // -------------------------------------------------------------------------
  // Next state and datapath controls
  // -------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    err_code_d   = err_code_q;
    retire_en    = 1'b0;

    pc_write_o   = 1'b0;
    ir_write_o   = 1'b0;
    iord_o       = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    reg_write_o  = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = 2'b00;
    ext_zero_o   = 1'b0;
    alu_op_o     = 2'b00;
    pc_src_o     = 2'b00;
    err_o        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_FETCH;
      end

      // PC <= PC + 4 and IR load happen on the same cycle memory delivers.
      S_FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = 2'b01;
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
        if (mem_ready_i) begin
          state_d = S_DECODE;
        end else if (wd_expired) begin
          state_d    = S_TRAP;
          err_code_d = ERR_TIMEOUT;
        end
      end

      // ALUOut <= PC + (sext(imm) << 2): branch target, ready for BRANCH.
      S_DECODE: begin
        alu_src_b_o = 2'b11;
        case (opcode_i)
          OP_RTYPE:    state_d = S_EXEC_R;
          OP_ORI:      state_d = S_EXEC_ORI;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:      state_d = S_BRANCH;
          OP_J:        state_d = S_JUMP;
          default: begin
            state_d    = S_TRAP;
            err_code_d = ERR_ILLEGAL;
          end
        endcase
      end

      S_EXEC_R: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = 2'b10;
        state_d     = S_WB_R;
      end

      S_EXEC_ORI: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        ext_zero_o  = 1'b1;
        alu_op_o    = 2'b11;
        state_d     = S_WB_R;
      end

      // Only lw and sw reach here, so anything that is not sw is a load.
      S_MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        state_d     = (opcode_i == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end

      S_MEM_RD: begin
        mem_read_o = 1'b1;
        iord_o     = 1'b1;
        if (mem_ready_i) begin
          state_d = S_WB_MEM;
        end else if (wd_expired) begin
          state_d    = S_TRAP;
          err_code_d = ERR_TIMEOUT;
        end
      end

      // A store retires as soon as memory accepts it; no write-back follows.
      S_MEM_WR: begin
        mem_write_o = 1'b1;
        iord_o      = 1'b1;
        if (mem_ready_i) begin
          state_d   = S_FETCH;
          retire_en = 1'b1;
        end else if (wd_expired) begin
          state_d    = S_TRAP;
          err_code_d = ERR_TIMEOUT;
        end
      end

      // R-type writes rd; ori shares this state and writes rt.
      S_WB_R: begin
        reg_write_o = 1'b1;
        reg_dst_o   = (opcode_i == OP_RTYPE);
        state_d     = S_FETCH;
        retire_en   = 1'b1;
      end

      S_WB_MEM: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
        state_d      = S_FETCH;
        retire_en    = 1'b1;
      end

      // Compare rs - rt; the PC only loads the precomputed target when equal.
      S_BRANCH: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = 2'b01;
        pc_src_o    = 2'b01;
        pc_write_o  = zero_i;
        state_d     = S_FETCH;
        retire_en   = 1'b1;
      end

      S_JUMP: begin
        pc_src_o   = 2'b10;
        pc_write_o = 1'b1;
        state_d    = S_FETCH;
        retire_en  = 1'b1;
      end

      // Sticky until reset; start_i is deliberately not looked at.
      S_TRAP: begin
        err_o = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    retire_d = retire_en ? (retire_q + CNT_W'(1)) : retire_q;
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= S_IDLE;
      wd_q       <= '0;
      err_code_q <= '0;
      retire_q   <= '0;
    end else begin
      state_q    <= state_d;
      wd_q       <= wd_d;
      err_code_q <= err_code_d;
      retire_q   <= retire_d;
    end
  end

  assign state_o      = state_q;
  assign err_code_o   = err_code_q;
  assign retire_cnt_o = retire_q;

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// Bench for multicycle_control. Instructions are described at the level of
// "which states does this instruction visit, and for how long", built from
// the instruction class and the number of memory wait cycles; the expected
// controls for each visited state come from a lookup table of the documented
// per-state outputs.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

  localparam int TMO = 4;
  localparam int CW  = 3;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;

  logic          clk = 1'b0;
  logic          rst_i = 1'b0;
  logic          start_i = 1'b0;
  logic [5:0]    opcode_i = '0;
  logic          zero_i = 1'b0;
  logic          mem_ready_i = 1'b0;
  logic          pc_write_o, ir_write_o, iord_o, mem_read_o, mem_write_o;
  logic          reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o;
  logic [1:0]    alu_src_b_o;
  logic          ext_zero_o;
  logic [1:0]    alu_op_o, pc_src_o;
  logic [3:0]    state_o;
  logic          err_o;
  logic [1:0]    err_code_o;
  logic [CW-1:0] retire_cnt_o;

  multicycle_control #(
    .OP_W(6), .TMO_W(8), .MEM_TIMEOUT(TMO), .CNT_W(CW)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .opcode_i(opcode_i),
    .zero_i(zero_i), .mem_ready_i(mem_ready_i),
    .pc_write_o(pc_write_o), .ir_write_o(ir_write_o), .iord_o(iord_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .reg_write_o(reg_write_o), .reg_dst_o(reg_dst_o),
    .mem_to_reg_o(mem_to_reg_o), .alu_src_a_o(alu_src_a_o),
    .alu_src_b_o(alu_src_b_o), .ext_zero_o(ext_zero_o), .alu_op_o(alu_op_o),
    .pc_src_o(pc_src_o), .state_o(state_o), .err_o(err_o),
    .err_code_o(err_code_o), .retire_cnt_o(retire_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       rdy;
    logic       start;
    logic [1:0] code;
  } ent_t;

  ent_t       sched[$];
  logic [5:0] cur_op;
  logic       cur_zero;
  bit         will_retire;
  int         exp_ret;
  int         n_vec;
  int         n_miss;

  // Documented per-state controls, packed as
  // {pc_write, ir_write, iord, mem_read, mem_write, reg_write, reg_dst,
  //  mem_to_reg, alu_src_a, alu_src_b[2], ext_zero, alu_op[2], pc_src[2], err}
  function automatic logic [16:0] exp_ctrl(input int st, input logic rdy,
                                           input logic z, input logic [5:0] op);
    logic pcw, irw, iord, mr, mwr, rw, rd, m2r, asa, ez, err;
    logic [1:0] asb, aop, psrc;
    pcw = 0; irw = 0; iord = 0; mr = 0; mwr = 0; rw = 0; rd = 0; m2r = 0;
    asa = 0; ez = 0; err = 0; asb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (st)
      1:  begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
      2:  asb = 2'b11;
      3:  begin asa = 1; aop = 2'b10; end
      4:  begin asa = 1; asb = 2'b10; ez = 1; aop = 2'b11; end
      5:  begin asa = 1; asb = 2'b10; end
      6:  begin mr = 1; iord = 1; end
      7:  begin mwr = 1; iord = 1; end
      8:  begin rw = 1; rd = (op == 6'b000000); end
      9:  begin rw = 1; m2r = 1; end
      10: begin asa = 1; aop = 2'b01; psrc = 2'b01; pcw = z; end
      11: begin psrc = 2'b10; pcw = 1; end
      12: err = 1;
      default: ;
    endcase
    return {pcw, irw, iord, mr, mwr, rw, rd, m2r, asa, asb, ez, aop, psrc, err};
  endfunction

  function automatic logic [25:0] expv(input ent_t e);
    return {e.st, exp_ctrl(int'(e.st), e.rdy, cur_zero, cur_op), e.code,
            CW'(exp_ret)};
  endfunction

  function automatic logic [25:0] obs();
    return {state_o, pc_write_o, ir_write_o, iord_o, mem_read_o, mem_write_o,
            reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o,
            ext_zero_o, alu_op_o, pc_src_o, err_o, err_code_o, retire_cnt_o};
  endfunction

  task automatic push(input int st, input logic rdy, input logic start,
                      input logic [1:0] code);
    ent_t e;
    e.st = 4'(st); e.rdy = rdy; e.start = start; e.code = code;
    sched.push_back(e);
  endtask

  // A wait state is held for w stalled cycles then one ready cycle, unless
  // w reaches the timeout, in which case it traps after TMO stalled cycles.
  task automatic push_wait(input int st, input int w, output bit ok);
    ok = 1'b1;
    if (w >= TMO) begin
      for (int i = 0; i < TMO; i++) push(st, 1'b0, 1'b0, 2'b00);
      push(12, 1'($urandom), 1'b0, 2'b10);
      ok = 1'b0;
    end else begin
      for (int i = 0; i < w; i++) push(st, 1'b0, 1'b0, 2'b00);
      push(st, 1'b1, 1'b0, 2'b00);
    end
  endtask

  task automatic build(input logic [5:0] op, input logic z, input int fw,
                       input int mw, input bit from_idle);
    bit ok;
    sched.delete();
    cur_op = op; cur_zero = z; will_retire = 1'b0;
    if (from_idle) push(0, 1'($urandom), 1'b1, 2'b00);
    push_wait(1, fw, ok);
    if (!ok) return;
    push(2, 1'($urandom), 1'b0, 2'b00);
    case (op)
      OP_R:   begin push(3, 1'($urandom), 0, 0); push(8, 1'($urandom), 0, 0); end
      OP_ORI: begin push(4, 1'($urandom), 0, 0); push(8, 1'($urandom), 0, 0); end
      OP_LW: begin
        push(5, 1'($urandom), 0, 0);
        push_wait(6, mw, ok);
        if (!ok) return;
        push(9, 1'($urandom), 0, 0);
      end
      OP_SW: begin
        push(5, 1'($urandom), 0, 0);
        push_wait(7, mw, ok);
        if (!ok) return;
      end
      OP_BEQ: push(10, 1'($urandom), 0, 0);
      OP_J:   push(11, 1'($urandom), 0, 0);
      default: begin
        push(12, 1'($urandom), 1'b0, 2'b01);
        return;
      end
    endcase
    will_retire = 1'b1;
  endtask

  task automatic retire_model();
    if (will_retire) exp_ret = (exp_ret + 1) % (1 << CW);
  endtask

  task automatic drive_cycle(input ent_t e);
    @(negedge clk);
    start_i = e.start; opcode_i = cur_op; zero_i = cur_zero;
    mem_ready_i = e.rdy;
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_i = 1'b0; start_i = 1'b0; mem_ready_i = 1'b0; zero_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b1; exp_ret = 0;
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_vec++;
    if (obs() !== 26'd0) begin
      n_miss++;
      $display("FAIL reset: got %h, expected %h", obs(), 26'd0);
    end
  endtask

  task automatic test_r_type();
    apply_reset();
    build(OP_R, 1'b0, 0, 0, 1'b1);
    foreach (sched[i]) begin
      drive_cycle(sched[i]); n_vec++;
      if (obs() !== expv(sched[i])) begin
        n_miss++;
        $display("FAIL r_type[%0d]: got %h, expected %h", i, obs(), expv(sched[i]));
      end
    end
    retire_model();
    @(posedge clk); #1;
    n_vec++;
    if (state_o !== 4'd1 || retire_cnt_o !== 3'd1) begin
      n_miss++;
      $display("FAIL r_type_retire: got st=%0d cnt=%0d, expected st=1 cnt=1",
               state_o, retire_cnt_o);
    end
  endtask

  task automatic test_lw_wait();
    apply_reset();
    build(OP_LW, 1'b0, 0, 3, 1'b1);
    foreach (sched[i]) begin
      drive_cycle(sched[i]); n_vec++;
      if (obs() !== expv(sched[i])) begin
        n_miss++;
        $display("FAIL lw_wait[%0d]: got %h, expected %h", i, obs(), expv(sched[i]));
      end
    end
    retire_model();
  endtask

  task automatic test_beq();
    apply_reset();
    for (int k = 0; k < 2; k++) begin
      build(OP_BEQ, (k == 0), 0, 0, (k == 0));
      foreach (sched[i]) begin
        drive_cycle(sched[i]); n_vec++;
        if (obs() !== expv(sched[i])) begin
          n_miss++;
          $display("FAIL beq_z%0d[%0d]: got %h, expected %h", (k == 0), i,
                   obs(), expv(sched[i]));
        end
      end
      retire_model();
    end
  endtask

  task automatic test_illegal();
    apply_reset();
    build(6'b111111, 1'b0, 0, 0, 1'b1);
    for (int i = 0; i < 3; i++) push(12, 1'($urandom), 1'b1, 2'b01);
    foreach (sched[i]) begin
      drive_cycle(sched[i]); n_vec++;
      if (obs() !== expv(sched[i])) begin
        n_miss++;
        $display("FAIL illegal[%0d]: got %h, expected %h", i, obs(), expv(sched[i]));
      end
    end
    apply_reset();
    n_vec++;
    if (obs() !== 26'd0) begin
      n_miss++;
      $display("FAIL illegal_reset: got %h, expected %h", obs(), 26'd0);
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    build(OP_J, 1'b0, TMO, 0, 1'b1);
    for (int i = 0; i < 2; i++) push(12, 1'($urandom), 1'b1, 2'b10);
    foreach (sched[i]) begin
      drive_cycle(sched[i]); n_vec++;
      if (obs() !== expv(sched[i])) begin
        n_miss++;
        $display("FAIL timeout[%0d]: got %h, expected %h", i, obs(), expv(sched[i]));
      end
    end
    apply_reset();
    build(OP_J, 1'b0, TMO - 1, 0, 1'b1);
    foreach (sched[i]) begin
      drive_cycle(sched[i]); n_vec++;
      if (obs() !== expv(sched[i])) begin
        n_miss++;
        $display("FAIL ready_at_limit[%0d]: got %h, expected %h", i, obs(),
                 expv(sched[i]));
      end
    end
    retire_model();
  endtask

  task automatic test_random();
    logic [5:0] ops[7];
    logic [5:0] op;
    bit first;
    int fw, mw;
    ops = '{OP_R, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_LW};
    apply_reset();
    first = 1'b1;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        do op = 6'($urandom);
        while (op == OP_R || op == OP_ORI || op == OP_LW || op == OP_SW ||
               op == OP_BEQ || op == OP_J);
      end else begin
        op = ops[$urandom_range(0, 6)];
      end
      fw = ($urandom_range(0, 11) == 0) ? $urandom_range(TMO, TMO + 1) : $urandom_range(0, 2);
      mw = ($urandom_range(0, 5) == 0) ? $urandom_range(TMO - 1, TMO + 1) : $urandom_range(0, 2);
      build(op, 1'($urandom), fw, mw, first);
      foreach (sched[i]) begin
        drive_cycle(sched[i]); n_vec++;
        if (obs() !== expv(sched[i])) begin
          n_miss++;
          $display("FAIL random[%0d.%0d] op=%b: got %h, expected %h", n, i, op,
                   obs(), expv(sched[i]));
        end
      end
      retire_model();
      first = !will_retire;
      if (!will_retire) apply_reset();
    end
  endtask

  task automatic test_wrap_and_reset();
    apply_reset();
    for (int k = 0; k < 9; k++) begin
      build(OP_J, 1'($urandom), $urandom_range(0, 2), 0, (k == 0));
      foreach (sched[i]) begin
        drive_cycle(sched[i]); n_vec++;
        if (obs() !== expv(sched[i])) begin
          n_miss++;
          $display("FAIL wrap_j%0d[%0d]: got %h, expected %h", k, i, obs(),
                   expv(sched[i]));
        end
      end
      retire_model();
    end
    @(posedge clk); #1;
    n_vec++;
    if (retire_cnt_o !== 3'd1) begin
      n_miss++;
      $display("FAIL retire_wrap: got %0d, expected 1", retire_cnt_o);
    end
    build(OP_SW, 1'b0, 0, 3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive_cycle(sched[i]); n_vec++;
      if (obs() !== expv(sched[i])) begin
        n_miss++;
        $display("FAIL sw_pre_reset[%0d]: got %h, expected %h", i, obs(),
                 expv(sched[i]));
      end
    end
    @(negedge clk);
    rst_i = 1'b0; mem_ready_i = 1'b0;
    #1;
    n_vec++;
    if (state_o !== 4'd7 || mem_write_o !== 1'b1) begin
      n_miss++;
      $display("FAIL sync_reset_hold: got st=%0d mw=%b, expected st=7 mw=1",
               state_o, mem_write_o);
    end
    @(negedge clk);
    rst_i = 1'b1; exp_ret = 0;
    #1;
    n_vec++;
    if (obs() !== 26'd0) begin
      n_miss++;
      $display("FAIL reset_mid_memwr: got %h, expected %h", obs(), 26'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss + 1);
    $fatal(1);
  end

  initial begin
    n_vec = 0; n_miss = 0; exp_ret = 0;
    cur_op = '0; cur_zero = 1'b0; will_retire = 1'b0;
    test_reset();
    test_r_type();
    test_lw_wait();
    test_beq();
    test_illegal();
    test_timeout();
    test_random();
    test_wrap_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
